// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter
//   Round-robin arbiter that lets NREQ requesters write one of NREG bank
//   registers over a shared d bus. Each transaction runs three cycles:
//   IDLE (sample req) -> WRITE (one reg_we pulse) -> ACK (ack/err pulse).
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-low reset
//   req     [NREQ]        level write requests
//   addr    [NREQ*AW]     per-requester register index, slice i = [i*AW +: AW]
//   wdata   [NREQ*WIDTH]  per-requester write data, slice i = [i*WIDTH +: WIDTH]
//   gnt     [NREQ]        one-hot grant, held through WRITE and ACK
//   ack     [NREQ]        one-cycle completion pulse in ACK
//   err     1             pulse with ack when the latched index is >= NREG
//   reg_we  [NREG]        one-hot bank write enables (WRITE only)
//   reg_d   [WIDTH]       shared bank data bus
//   busy    1             high whenever not IDLE
//
// AW must satisfy 2**AW >= NREG.
module reg_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      addr,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    err,
  output logic [NREG-1:0]         reg_we,
  output logic [WIDTH-1:0]        reg_d,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, win, win_nxt;
  logic            found;
  logic [AW-1:0]   laddr;
  logic [WIDTH-1:0] ldata;

  logic [AW-1:0]    addr_a  [NREQ];
  logic [WIDTH-1:0] wdata_a [NREQ];

  // per-requester slicing and grant/ack decode
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign addr_a[i]  = addr[i*AW +: AW];
    assign wdata_a[i] = wdata[i*WIDTH +: WIDTH];
    assign gnt[i]     = (state != IDLE) && (win == PW'(i));
    assign ack[i]     = (state == ACK)  && (win == PW'(i));
  end

  // An out-of-range index matches no decoder, so reg_we stays all-zero.
  for (genvar j = 0; j < NREG; j++) begin : g_we
    assign reg_we[j] = (state == WRITE) && (laddr == AW'(j));
  end

  // Round-robin pick: first asserted req scanning upward from ptr, wrapping.
  always_comb begin
    win_nxt = ptr;
    found   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NREQ]) begin
        found   = 1'b1;
        win_nxt = PW'((int'(ptr) + off) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = WRITE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner, address and data are captured only on leaving IDLE, so req/addr/
  // wdata activity during WRITE/ACK cannot disturb the transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr   <= '0;
      win   <= '0;
      laddr <= '0;
      ldata <= '0;
    end else begin
      if (state == IDLE && found) begin
        win   <= win_nxt;
        laddr <= addr_a[win_nxt];
        ldata <= wdata_a[win_nxt];
      end
      if (state == ACK)
        ptr <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
    end
  end

  // The latched data doubles as the bus, so it holds between writes.
  assign reg_d = ldata;
  assign err   = (state == ACK) && (int'(laddr) >= NREG);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [3:0]  gnt, ack;
  logic        err, busy;
  logic [7:0]  reg_we;
  logic [15:0] reg_d;

  int total = 0;
  int bad   = 0;
  int mptr;

  reg_bank_arbiter #(.WIDTH(16), .NREQ(4), .NREG(8), .AW(4)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .err(err), .reg_we(reg_we), .reg_d(reg_d),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] a;
    logic [63:0] d;
    logic [3:0]  eg;
    logic [7:0]  ewe;
    logic [15:0] ed;
    logic        eerr;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    rst = 1'b1;
  endtask

  // One transaction from IDLE, checked cycle by cycle through WRITE, ACK, IDLE.
  task automatic run_vec(int n, vec_t v);
    req = v.req; addr = v.a; wdata = v.d;
    tick();
    chk($sformatf("v%0d gnt", n), gnt, v.eg);
    chk($sformatf("v%0d we", n), reg_we, v.ewe);
    chk($sformatf("v%0d d", n), reg_d, v.ed);
    chk($sformatf("v%0d busy", n), busy, 1);
    req = '0;
    tick();
    chk($sformatf("v%0d ack", n), ack, v.eg);
    chk($sformatf("v%0d err", n), err, v.eerr);
    chk($sformatf("v%0d we_ack", n), reg_we, 0);
    tick();
    chk($sformatf("v%0d idle_busy", n), busy, 0);
    chk($sformatf("v%0d idle_gnt", n), gnt, 0);
  endtask

  // Reference model: winner by scanning requester indices from mptr.
  task automatic rand_txn(int n);
    logic [3:0]  r;
    logic [15:0] a;
    logic [63:0] d;
    int w;
    logic [3:0] aw;
    r = 4'($urandom_range(0, 15));
    a = 16'($urandom);
    d = {$urandom, $urandom};
    req = r; addr = a; wdata = d;
    tick();
    if (r == 0) begin
      chk($sformatf("r%0d idle_busy", n), busy, 0);
      return;
    end
    w = -1;
    for (int off = 0; off < 4; off++)
      if (w < 0 && r[(mptr + off) % 4]) w = (mptr + off) % 4;
    aw = a[w*4 +: 4];
    chk($sformatf("r%0d gnt", n), gnt, 64'(1) << w);
    chk($sformatf("r%0d we", n), reg_we, (aw < 8) ? (64'(1) << aw) : 64'(0));
    chk($sformatf("r%0d d", n), reg_d, d[w*16 +: 16]);
    req = 4'($urandom); addr = 16'($urandom); wdata = {$urandom, $urandom};
    tick();
    chk($sformatf("r%0d ack", n), ack, 64'(1) << w);
    chk($sformatf("r%0d err", n), err, (aw >= 8) ? 1 : 0);
    chk($sformatf("r%0d we_ack", n), reg_we, 0);
    req = 4'($urandom);
    tick();
    chk($sformatf("r%0d end_busy", n), busy, 0);
    mptr = (w + 1) % 4;
  endtask

  initial begin
    vecs[0] = '{4'b0010, 16'h0030, 64'h0000_0000_A5A5_0000, 4'b0010, 8'h08, 16'hA5A5, 1'b0};
    vecs[1] = '{4'b0001, 16'h0009, 64'h0000_0000_0000_1234, 4'b0001, 8'h00, 16'h1234, 1'b1};
    vecs[2] = '{4'b1111, 16'h7210, 64'h4444_3333_2222_1111, 4'b0010, 8'h02, 16'h2222, 1'b0};
    vecs[3] = '{4'b1001, 16'h7210, 64'h4444_3333_2222_1111, 4'b1000, 8'h80, 16'h4444, 1'b0};
    vecs[4] = '{4'b1001, 16'h700F, 64'h4444_0000_0000_BEEF, 4'b0001, 8'h00, 16'hBEEF, 1'b1};
    vecs[5] = '{4'b0100, 16'h0400, 64'h0000_CAFE_0000_0000, 4'b0100, 8'h10, 16'hCAFE, 1'b0};
    vecs[6] = '{4'b0011, 16'h0008, 64'h0000_0000_5555_7777, 4'b0001, 8'h00, 16'h7777, 1'b1};
    vecs[7] = '{4'b0011, 16'h0008, 64'h0000_0000_5555_7777, 4'b0010, 8'h01, 16'h5555, 1'b0};

    // reset held two cycles with all requests high
    rst = 1'b0; req = 4'b1111; addr = 16'h3210; wdata = 64'h1111_2222_3333_4444;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst gnt", gnt, 0);
      chk("rst ack", ack, 0);
      chk("rst err", err, 0);
      chk("rst we", reg_we, 0);
      chk("rst d", reg_d, 0);
      chk("rst busy", busy, 0);
    end
    rst = 1'b1; req = '0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // contention: all requests held, expect 0,1,2,3,0 with ack every 3 cycles
    do_reset();
    req = 4'b1111; addr = 16'h3210; wdata = 64'h4444_3333_2222_1111;
    for (int t = 1; t <= 15; t++) begin
      tick();
      chk($sformatf("rr ack t%0d", t), ack,
          (t % 3 == 2) ? (64'(1) << (((t - 2) / 3) % 4)) : 64'(0));
      chk($sformatf("rr gnt t%0d", t), gnt,
          (t % 3 != 0) ? (64'(1) << (((t - 1) / 3) % 4)) : 64'(0));
    end
    req = '0;

    // early drop: req2 lowered during WRITE still completes, no regrant
    do_reset();
    req = 4'b0100; addr = 16'h0500;
    tick();
    chk("drop gnt", gnt, 4'b0100);
    req = '0;
    tick();
    chk("drop ack", ack, 4'b0100);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("drop nogrant", gnt, 0);
    end

    // reset in WRITE: abandon, ptr back to 0
    do_reset();
    req = 4'b0001; addr = 16'h0001;
    tick(); req = '0; tick(); tick();          // ptr -> 1
    req = 4'b0010;
    tick();
    chk("mid gnt", gnt, 4'b0010);
    rst = 1'b0; req = '0;
    tick();
    chk("mid busy", busy, 0);
    chk("mid gnt0", gnt, 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid noack", ack, 0);
      chk("mid nowe", reg_we, 0);
    end
    req = 4'b0011;
    tick();
    chk("mid ptr0", gnt, 4'b0001);
    req = '0; tick(); tick();
    req = 4'b0100;
    tick();
    chk("mid g2", gnt, 4'b0100);
    req = '0; tick(); tick();

    // randomized transactions against the model
    do_reset();
    mptr = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_reset();
        mptr = 0;
      end
      rand_txn(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
